// File: rtl/sumres_pkg.sv
// Shared definitions for the serial adder/subtractor: opcodes, FSM encoding,
// the single-bit full-adder cell and a counter-width helper.
package sumres_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Returns {carry_out, sum}
  function automatic logic [1:0] sum1b(input logic x, input logic y, input logic ci);
    logic p;
    p = x ^ y;
    return {(x & y) | (ci & p), p ^ ci};
  endfunction

  // Chunk counter width: $clog2(n), never below one bit
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sum_chunk.sv
// W-bit ripple-carry slice built from sum1b cells; also exports the carry
// entering the top bit so the caller can derive signed overflow.
module sum_chunk
  import sumres_pkg::*;
#(
  parameter int W = 1
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Ci,
  output logic [W-1:0] Sum,
  output logic         Cout,
  output logic         Cmsb
);

  logic cy;

  always_comb begin
    cy   = Ci;
    Cmsb = Ci;
    Sum  = '0;
    for (int i = 0; i < W; i++) begin
      Cmsb = cy;
      {cy, Sum[i]} = sum1b(A[i], B[i], cy);
    end
    Cout = cy;
  end

endmodule

// File: rtl/sumres_serial.sv
// Multi-cycle two's-complement adder/subtractor: one CHUNK-bit slice per clock,
// LSB chunk first, with start/busy/done handshake and carry/overflow/zero flags.
module sumres_serial
  import sumres_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("sumres_serial: WIDTH must be >= 2 and an exact multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [CHUNK-1:0] sl_a, sl_b, sl_sum;
  logic             sl_cout, sl_cmsb;
  logic [WIDTH-1:0] res_wr;

  // Operand chunk selected by the counter
  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) begin
        sl_a = a_q[i*CHUNK +: CHUNK];
        sl_b = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  sum_chunk #(
    .W(CHUNK)
  ) u_slice (
    .A   (sl_a),
    .B   (sl_b),
    .Ci  (carry_q),
    .Sum (sl_sum),
    .Cout(sl_cout),
    .Cmsb(sl_cmsb)
  );

  // Result with the current chunk merged in at its bit position
  always_comb begin
    res_wr = result_q;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) begin
        res_wr[i*CHUNK +: CHUNK] = sl_sum;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert b here, seed the carry with op
          state_d  = ST_RUN;
          cnt_d    = '0;
          a_d      = a;
          b_d      = (op == OP_ADD) ? b : ~b;
          carry_d  = (op == OP_SUB);
          result_d = '0;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
          zero_d   = 1'b0;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        result_d = res_wr;
        carry_d  = sl_cout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          cout_d  = sl_cout;
          ovf_d   = sl_cmsb ^ sl_cout;
          zero_d  = ~|res_wr;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_sumres_serial.sv
// Scoreboard bench for sumres_serial: WIDTH=8 with CHUNK=1 and CHUNK=4,
// directed corner cases followed by random operations.
module tb_sumres_serial;

  localparam int WIDTH = 8;

  typedef struct {
    logic [7:0] res;
    logic       cout;
    logic       ovf;
    logic       zero;
    int         done_cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int phase  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands
  function automatic exp_t ref_op(input logic o, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int   sx, sy, sr, ur;
    sx = $signed(x);
    sy = $signed(y);
    if (o) begin
      ur     = int'(x) - int'(y);
      sr     = sx - sy;
      e.cout = (x >= y);
    end else begin
      ur     = int'(x) + int'(y);
      sr     = sx + sy;
      e.cout = (ur > 255);
    end
    e.res      = ur[7:0];
    e.ovf      = (sr > 127) || (sr < -128);
    e.zero     = (e.res == 8'h00);
    e.done_cyc = 0;
    return e;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int CH = (g == 0) ? 1 : 4;
    localparam int N  = WIDTH / CH;

    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       op = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       busy, done, cout, ovf, zero;
    logic [7:0] result;

    exp_t       q[$];
    int         done_log[$];
    int         cyc = 0;
    int         last_t0 = -1000;
    bit         mon_en = 1'b0;
    logic [7:0] h_res = 8'h00;
    logic       h_cout = 1'b0, h_ovf = 1'b0, h_zero = 1'b0;

    sumres_serial #(
      .WIDTH(WIDTH),
      .CHUNK(CH)
    ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .result(result),
      .cout  (cout),
      .ovf   (ovf),
      .zero  (zero)
    );

    // Cycle k = interval after edge k. A run accepted at edge t0 is busy in
    // cycles t0..t0+N-1 and reports in cycle t0+N.
    always @(posedge clk) begin
      int   prev;
      exp_t e;
      prev = cyc;
      cyc  = cyc + 1;
      if (rst) begin
        last_t0 = -1000;
      end else if (start && !(prev >= last_t0 && prev <= last_t0 + N - 1)) begin
        e          = ref_op(op, a, b);
        e.done_cyc = cyc + N;
        q.push_back(e);
        last_t0    = cyc;
      end
    end

    always @(negedge clk) begin
      bit   exp_busy, exp_done;
      exp_t e;
      if (mon_en && !rst) begin
        exp_busy = (cyc >= last_t0) && (cyc <= last_t0 + N - 1);
        exp_done = (q.size() > 0) && (q[0].done_cyc == cyc);
        chk($sformatf("c%0d_busy@%0d", CH, cyc), busy, exp_busy);
        chk($sformatf("c%0d_done@%0d", CH, cyc), done, exp_done);
        if (exp_done) begin
          e = q.pop_front();
          chk($sformatf("c%0d_result", CH), result, e.res);
          chk($sformatf("c%0d_cout", CH), cout, e.cout);
          chk($sformatf("c%0d_ovf", CH), ovf, e.ovf);
          chk($sformatf("c%0d_zero", CH), zero, e.zero);
          h_res  = e.res;
          h_cout = e.cout;
          h_ovf  = e.ovf;
          h_zero = e.zero;
          done_log.push_back(cyc);
        end else if (exp_busy) begin
          chk($sformatf("c%0d_run_flags", CH), {cout, ovf, zero}, 0);
        end else begin
          chk($sformatf("c%0d_hold_result", CH), result, h_res);
          chk($sformatf("c%0d_hold_flags", CH), {cout, ovf, zero}, {h_cout, h_ovf, h_zero});
        end
      end
    end

    task automatic step();
      @(negedge clk);
      #1;
    endtask

    task automatic issue(input logic o, input logic [7:0] x, input logic [7:0] y);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      step();
      start = 1'b0;
    endtask

    task automatic wait_idle();
      int k;
      k = 0;
      while (q.size() != 0 && k < 4 * N + 8) begin
        step();
        k++;
      end
      chk($sformatf("c%0d_drain_timeout", CH), q.size(), 0);
      q.delete();
    endtask

    task automatic chk_all_zero(input string nm);
      chk($sformatf("c%0d_%s", CH, nm), {busy, done, result, cout, ovf, zero}, 0);
    endtask

    initial begin
      int n0, n;
      while (phase != g) @(negedge clk);
      repeat (2) step();
      chk_all_zero("reset_state");
      rst    = 1'b0;
      mon_en = 1'b1;
      step();

      // Basic add, subtract with borrow, zero result, signed overflow
      issue(1'b0, 8'h35, 8'h12); wait_idle();
      issue(1'b1, 8'h05, 8'h07); wait_idle();
      issue(1'b1, 8'h07, 8'h07); wait_idle();
      issue(1'b0, 8'h7F, 8'h01); wait_idle();
      issue(1'b1, 8'h80, 8'h01); wait_idle();
      issue(1'b0, 8'hFF, 8'h01); wait_idle();
      step();

      // Start pulsed mid-run with other operands must be ignored
      issue(1'b0, 8'h10, 8'h20);
      issue(1'b1, 8'hAA, 8'h55);
      wait_idle();
      step();

      // Start held through DONE: second op accepted back-to-back
      n0    = done_log.size();
      start = 1'b1; op = 1'b0; a = 8'h21; b = 8'h43;
      step();
      op = 1'b1; a = 8'h50; b = 8'h60;
      repeat (N + 1) step();
      start = 1'b0;
      wait_idle();
      n = done_log.size();
      chk($sformatf("c%0d_b2b_count", CH), n - n0, 2);
      if (n - n0 >= 2)
        chk($sformatf("c%0d_b2b_spacing", CH), done_log[n-1] - done_log[n-2], N + 1);
      step();

      // Asynchronous reset in the middle of a run
      issue(1'b0, 8'h33, 8'h44);
      if (N > 2) step();
      #2 rst = 1'b1;
      #1 chk_all_zero("async_reset");
      q.delete();
      h_res = 8'h00; h_cout = 1'b0; h_ovf = 1'b0; h_zero = 1'b0;
      step();
      step();
      rst = 1'b0;
      repeat (3) step();
      issue(1'b1, 8'h9C, 8'h3A); wait_idle();

      // Random operations with 0..2 idle cycles between them
      for (int i = 0; i < 30; i++) begin
        issue(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        wait_idle();
        repeat ($urandom_range(0, 2)) step();
      end
      repeat (3) step();
      mon_en = 1'b0;
      phase  = g + 1;
    end
  end

  initial begin
    for (int t = 0; t < 20000 && phase < 2; t++) @(posedge clk);
    if (phase < 2) begin
      errors++;
      $display("FAIL run_timeout got phase %0d expected 2", phase);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
